uart_rx_fifo: RTL and testbench

Receive-side buffer sitting directly downstream of the UART receiver. It captures each received byte on the receiver's one-cycle ready pulse and each framing-error pulse. Bytes are stored in a circular FIFO, and the block tracks framing errors and overruns. The host/bus side drains it with a simple registered read handshake, so back-to-back frames are not lost while the consumer is busy.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_fifo_mem.sv | 39 +++
 rtl/uart_rx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths, FIFO depth and the frame-status record
// reused by the receive buffer, the transmit side and the register block.
package uart_pkg;

  localparam int unsigned UartDataW     = 8;
  localparam int unsigned UartFifoAddrW = 4;
  localparam int unsigned UartFifoDepth = 2 ** UartFifoAddrW;
  localparam int unsigned UartErrCntW   = 8;

  typedef struct packed {
    logic overrun;
    logic frame_err;
  } frame_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Plain register-array FIFO storage: one write port, one registered read port.
// Only the read register is reset; array contents are never read before being written.
module uart_fifo_mem #(
  parameter int unsigned DataW = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A read and write to the same slot return the old contents (full push+pop case).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver: circular byte FIFO with registered
// pop, sticky overrun/framing flags and a saturating framing-error counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W   = UartDataW,
  parameter int unsigned ADDR_W   = UartFifoAddrW,
  parameter int unsigned ERRCNT_W = UartErrCntW
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [DATA_W-1:0]   rx_data_i,
  input  logic                rx_ready_i,
  input  logic                rx_err_i,
  input  logic                rd_en_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [ADDR_W:0]     count_o,
  output logic                overrun_o,
  output logic                frame_err_o,
  output logic [ERRCNT_W-1:0] err_count_o,
  input  logic                err_clr_i
);

  localparam logic [ADDR_W:0]     DepthCnt = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]     CntOne   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0]   PtrOne   = ADDR_W'(1);
  localparam logic [ERRCNT_W-1:0] ErrOne   = ERRCNT_W'(1);
  localparam logic [ERRCNT_W-1:0] ErrMax   = {ERRCNT_W{1'b1}};

  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                rd_valid_q;
  frame_status_t       status_q, status_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  logic empty, full, push, pop, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  // Pop is decided first so a full FIFO can accept a push in the same cycle;
  // an empty FIFO never forwards the incoming byte straight to the reader.
  assign pop  = rd_en_i & ~empty;
  assign push = rx_ready_i & (~full | pop);
  assign drop = rx_ready_i & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (!push && pop) begin
      count_d = count_q - CntOne;
    end
  end

  // Clear first, then let any same-cycle event set the flag again.
  always_comb begin
    status_d    = err_clr_i ? '0 : status_q;
    err_count_d = err_clr_i ? '0 : err_count_q;
    if (drop) begin
      status_d.overrun = 1'b1;
    end
    if (rx_err_i) begin
      status_d.frame_err = 1'b1;
      if (err_count_d != ErrMax) begin
        err_count_d = err_count_d + ErrOne;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      status_q    <= '0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= pop;
      status_q    <= status_d;
      err_count_q <= err_count_d;
    end
  end

  uart_fifo_mem #(
    .DataW (DATA_W),
    .AddrW (ADDR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_data_i),
    .re_i    (pop),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_o)
  );

  assign rd_valid_o  = rd_valid_q;
  assign empty_o     = empty;
  assign full_o      = full;
  assign count_o     = count_q;
  assign overrun_o   = status_q.overrun;
  assign frame_err_o = status_q.frame_err;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and random stimulus for uart_rx_fifo, checked every cycle against a
// queue-based model of the receive buffer and its error flags.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_ready = 1'b0;
  logic       rx_err = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, empty, full, overrun, frame_err;
  logic [4:0] count;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [7:0] mq[$];
  logic [7:0] m_rd_data = '0;
  logic       m_rd_valid = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;
  int         m_errcnt = 0;

  uart_rx_fifo dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .rx_data_i   (rx_data),
    .rx_ready_i  (rx_ready),
    .rx_err_i    (rx_err),
    .rd_en_i     (rd_en),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .empty_o     (empty),
    .full_o      (full),
    .count_o     (count),
    .overrun_o   (overrun),
    .frame_err_o (frame_err),
    .err_count_o (err_count),
    .err_clr_i   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":rd_valid"}, 32'(rd_valid), 32'(m_rd_valid));
    chk({ctx, ":rd_data"}, 32'(rd_data), 32'(m_rd_data));
    chk({ctx, ":count"}, 32'(count), 32'(mq.size()));
    chk({ctx, ":empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({ctx, ":full"}, 32'(full), 32'(mq.size() == 16));
    chk({ctx, ":overrun"}, 32'(overrun), 32'(m_ovr));
    chk({ctx, ":frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({ctx, ":err_count"}, 32'(err_count), 32'(m_errcnt));
  endtask

  task automatic model_reset();
    mq.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovr      = 1'b0;
    m_ferr     = 1'b0;
    m_errcnt   = 0;
  endtask

  // One clock cycle: drive inputs, advance the model, check outputs 1ns after the edge.
  task automatic step(input string ctx, input logic rdy, input logic [7:0] d, input logic err,
                      input logic rd, input logic clr);
    bit do_pop;
    rx_ready = rdy;
    rx_data  = d;
    rx_err   = err;
    rd_en    = rd;
    err_clr  = clr;
    do_pop = rd && (mq.size() > 0);
    m_rd_valid = do_pop;
    if (do_pop) m_rd_data = mq.pop_front();
    if (clr) begin
      m_ovr    = 1'b0;
      m_ferr   = 1'b0;
      m_errcnt = 0;
    end
    if (rdy) begin
      if (mq.size() < 16) mq.push_back(d);
      else m_ovr = 1'b1;
    end
    if (err) begin
      m_ferr = 1'b1;
      if (m_errcnt < 255) m_errcnt++;
    end
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    rx_err   = 1'b0;
    rd_en    = 1'b0;
    err_clr  = 1'b0;
    check_all(ctx);
  endtask

  task automatic push(input string ctx, input logic [7:0] d);
    step(ctx, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop(input string ctx);
    step(ctx, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] tri_bytes [3];
    tri_bytes = '{8'hA5, 8'h3C, 8'h7E};

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    foreach (tri_bytes[i]) push("basic_push", tri_bytes[i]);
    for (int i = 0; i < 3; i++) pop("basic_pop");
    step("idle_after_pop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    pop("pop_empty");

    for (int i = 0; i < 16; i++) push("fill", 8'(i));
    push("overrun", 8'hFF);
    for (int i = 0; i < 16; i++) pop("drain");
    pop("drain_extra");
    step("clr_ovr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) push("refill", 8'(i));
    step("full_push_pop", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) pop("drain2");

    step("empty_push_pop", 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    pop("empty_push_pop_out");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      push("wrap_push", b);
      pop("wrap_pop");
    end

    for (int i = 0; i < 300; i++) step("rx_err", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("clr_with_err", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step("lone_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("rdy_and_err", 1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
    pop("rdy_and_err_pop");

    for (int i = 0; i < 400; i++) begin
      logic rdy, err, rd, clr;
      rdy = ($urandom_range(0, 99) < 55);
      err = ($urandom_range(0, 99) < 8);
      rd  = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 4);
      step("random", rdy, 8'($urandom), err, rd, clr);
    end

    while (mq.size() < 16) push("pre_reset_fill", 8'($urandom));
    push("pre_reset_ovr", 8'hEE);
    for (int i = 0; i < 11; i++) pop("pre_reset_pop");
    chk("pre_reset_count", 32'(count), 32'd5);

    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset_idle");
    push("post_reset_push", 8'h81);
    pop("post_reset_pop");
    chk("post_reset_data", 32'(rd_data), 32'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
